// File: rtl/reset_pulse_ctrl_pkg.sv
// Shared types and default constants for the reset pulse sequencer.
package reset_pulse_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRelease,
    StFin
  } state_e;

  localparam int unsigned CNTW_DEFAULT    = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/reset_pulse_ctrl_if.sv
// Request/feedback bundle between a controller, the sequencer and the reset generator.
interface reset_pulse_ctrl_if #(
  parameter int unsigned CNTW = 8
);
  logic            REQ;
  logic [CNTW-1:0] LEN;
  logic            DST_RST_N;
  logic            ASSERT;
  logic            BUSY;
  logic            DONE;
  logic            ERR;

  modport master (
    output REQ,
    output LEN,
    output DST_RST_N,
    input  ASSERT,
    input  BUSY,
    input  DONE,
    input  ERR
  );

  modport slave (
    input  REQ,
    input  LEN,
    input  DST_RST_N,
    output ASSERT,
    output BUSY,
    output DONE,
    output ERR
  );
endinterface

// File: rtl/reset_sync_bit.sv
// Single-bit flop-chain synchronizer with asynchronous active-low clear to 0.
module reset_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_pulse_ctrl.sv
// Holds ASSERT for the reset generator until the destination reset is seen, then waits for release.
// Optional bounded waits with a sticky ERR flag: define RESET_CTRL_TIMEOUT_EN.
module reset_pulse_ctrl
  import reset_pulse_ctrl_pkg::*;
#(
  parameter int unsigned CNTW        = CNTW_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
  input logic               CLK,
  input logic               RST,
  reset_pulse_ctrl_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  logic fb;

  reset_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_fb_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (bus.DST_RST_N),
    .q  (fb)
  );

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            seen_low_q, seen_low_d;
  logic            assert_q, busy_q, done_q;
  logic            hold_exit;
  logic            timeout;

  assign hold_exit = (cnt_q == CNTW'(1)) && (seen_low_q || !fb);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    unique case (state_q)
      StIdle: begin
        if (bus.REQ) begin
          state_d    = StHold;
          cnt_d      = (bus.LEN == '0) ? CNTW'(1) : bus.LEN;
          seen_low_d = 1'b0;
        end
      end
      StHold: begin
        if (cnt_q > CNTW'(1)) cnt_d = cnt_q - CNTW'(1);
        if (!fb) seen_low_d = 1'b1;
        if (hold_exit) state_d = StRelease;
      end
      StRelease: begin
        if (fb) state_d = StFin;
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (timeout) state_d = StIdle;
  end

  // Outputs are registered from the next state so they line up with state_q and never glitch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      assert_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      assert_q   <= (state_d == StHold);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StFin);
    end
  end

  assign bus.ASSERT = assert_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

`ifdef RESET_CTRL_TIMEOUT_EN
  localparam int unsigned WAITW = $clog2(TIMEOUT + 1);

  logic [WAITW-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic             waiting;

  // Only cycles spent blocked on feedback are counted.
  assign waiting = ((state_q == StHold) && (cnt_q == CNTW'(1)) && !hold_exit) ||
                   ((state_q == StRelease) && !fb);
  assign timeout = waiting && (wait_q == WAITW'(TIMEOUT - 1));

  always_comb begin
    wait_d = wait_q;
    err_d  = err_q;
    if ((state_q == StIdle) && bus.REQ) begin
      wait_d = '0;
      err_d  = 1'b0;
    end else if ((state_q == StHold) && hold_exit) begin
      wait_d = '0;
    end else if (timeout) begin
      err_d  = 1'b1;
    end else if (waiting) begin
      wait_d = wait_q + WAITW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign bus.ERR = err_q;
`else
  assign timeout = 1'b0;
  assign bus.ERR = 1'b0;
`endif

endmodule

// File: doc/reset_pulse_ctrl.md
# reset_pulse_ctrl

Sequencer that drives the ASSERT input of the cross-domain reset generator and closes the loop on the destination-domain reset it produces. It accepts a one-cycle request and holds ASSERT for a programmable number of CLK cycles, at minimum until the destination reset is observed asserted. It then releases ASSERT, waits for the destination reset to deassert, and reports completion. It sits directly upstream of the reset generator in the CLK domain; the generator's destination reset output returns to this block as feedback.

## Interface
- CNTW, 8: width of LEN and of the hold counter.
- SYNC_STAGES, 2: flops in the feedback synchronizer (≥2).
- TIMEOUT, 1024: wait limit in CLK cycles; used only when the timeout feature is compiled in.

- CLK  in  1  source-domain clock; all state on posedge.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  1  start request; sampled only in IDLE.
- LEN  in  CNTW  minimum ASSERT duration in cycles; sampled with REQ; 0 is treated as 1.
- DST_RST_N  in  1  destination-domain reset (active-low), asynchronous to CLK.
- ASSERT  out  1  drives the reset generator; high asserts reset.
- BUSY  out  1  high whenever state ≠ IDLE.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  timeout flag; sticky.

## Operation
- DST_RST_N passes through a SYNC_STAGES synchronizer, reset to 0, giving fb. fb=0 means the destination is in reset.
- States: IDLE, HOLD, RELEASE, FIN.
- IDLE: if REQ=1, load cnt=max(LEN,1), clear seen_low and ERR, then go to HOLD. REQ=0 stays in IDLE.
- HOLD: ASSERT=1.
  - If cnt>1, decrement cnt.
  - Set seen_low when fb=0.
  - Exit to RELEASE when cnt==1 and (seen_low or fb==0).
- RELEASE: ASSERT=0. Go to FIN when fb==1.
- FIN: DONE=1 for one cycle, then return to IDLE.
- ASSERT, BUSY and DONE are registered, decoded from state, and glitch-free.
- REQ outside IDLE is ignored; requests are not queued.
- LEN changes outside the IDLE-with-REQ cycle have no effect.
- Reset mid-operation: RST low returns to IDLE immediately. ASSERT, BUSY, DONE and ERR go to 0, and the synchronizer is cleared.
- Reset values: ASSERT=0, BUSY=0, DONE=0, ERR=0, state=IDLE, cnt=0, seen_low=0.

## Timing
- REQ high at edge k in IDLE: BUSY=1 and ASSERT=1 from k+1.
- ASSERT is high for exactly the cycles spent in HOLD:
  - LEN cycles (min 1) if fb is already 0;
  - otherwise until the cycle fb first reads 0, if later.
- DST_RST_N change to fb change: SYNC_STAGES cycles.
- RELEASE lasts until fb=1, then one cycle in FIN (DONE=1). BUSY falls the cycle after FIN.
- Minimum total busy time with fb already 1 at release: LEN+2 cycles.
- A new REQ is accepted on the first cycle back in IDLE.

## Configuration
- RESET_CTRL_TIMEOUT_EN defined:
  - A wait counter clears on entry to HOLD and again on entry to RELEASE.
  - It counts while waiting on fb: in HOLD after cnt reaches 1, and in RELEASE.
  - On reaching TIMEOUT: ASSERT=0, ERR=1, return to IDLE, no DONE pulse.
  - ERR clears on the next accepted REQ or on RST.
- RESET_CTRL_TIMEOUT_EN undefined: waits are unbounded, ERR is tied to 0, and TIMEOUT is unused.

## Structure
- Shared package: the state enum (IDLE, HOLD, RELEASE, FIN) and the default constants for CNTW and TIMEOUT.
- One sub-module, reset_sync_bit: a SYNC_STAGES flop chain with async active-low reset to 0, used for DST_RST_N.
- The main module holds the FSM, cnt, seen_low, and the optional wait counter.

## Test plan
- Pre-asserted feedback: DST_RST_N=0, REQ with LEN=5. Required: ASSERT high exactly 5 cycles. Then drive DST_RST_N=1; DONE pulses 2+1 cycles later.
- Late feedback: DST_RST_N=1, REQ LEN=1; drop DST_RST_N 10 cycles later. Required: ASSERT high until fb reads 0 (10+2 cycles), then release, then DONE once DST_RST_N=1 propagates.
- Zero length: LEN=0 with fb=0. Required: ASSERT high exactly 1 cycle.
- Busy request: REQ pulses during HOLD and RELEASE. Required: ignored, exactly one DONE, BUSY continuous.
- Reset mid-HOLD: RST low in cycle 3 of HOLD (LEN=8). Required: ASSERT, BUSY, DONE and ERR at 0 immediately; after release, IDLE and a new REQ works.
- Timeout (with RESET_CTRL_TIMEOUT_EN, TIMEOUT=16): DST_RST_N stuck at 1, REQ LEN=2. Required: ERR=1 and ASSERT=0 after the 16-cycle wait, no DONE; the next REQ clears ERR.
